// File: rtl/cordic_fixedpoint_iteration_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_fixedpoint_iteration_ctrl
// Purpose  : Sequencer for the CORDIC phase-update and X/Y rotation datapath.
//            Optional macro CORDIC_CTRL_ABORT_EN adds the iAbort input.
// Revision : 1.0  initial release
// ============================================================================
module cordic_fixedpoint_iteration_ctrl #(
   parameter int N_ITER = 16
) (
   input  logic        iClk,
   input  logic        iReset_n,
   input  logic        iStart_valid,
   output logic        oStart_ready,
   input  logic [21:0] iPhase_in,
   output logic        oPhase_init_flag,
   output logic [21:0] oPhase_normalize,
   output logic [3:0]  oPhase_addr,
   input  logic        iPhase_sign,
   output logic        oRot_en,
   output logic        oRot_dir,
   output logic        oBusy,
   output logic        oDone_valid,
   input  logic        iDone_ready
`ifdef CORDIC_CTRL_ABORT_EN
   ,
   input  logic        iAbort
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [3:0] ITER_LAST = 4'(N_ITER - 1);

   logic [1:0]  state_q,     state_d;
   logic [3:0]  iter_cnt_q,  iter_cnt_d;
   logic [21:0] phase_cap_q, phase_cap_d;

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         state_q     <= ST_IDLE;
         iter_cnt_q  <= 4'd0;
         phase_cap_q <= 22'd0;
      end else begin
         state_q     <= state_d;
         iter_cnt_q  <= iter_cnt_d;
         phase_cap_q <= phase_cap_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      iter_cnt_d  = iter_cnt_q;
      phase_cap_d = phase_cap_q;
      case (state_q)
         ST_IDLE: begin
            if (iStart_valid) begin
               phase_cap_d = iPhase_in;
               iter_cnt_d  = 4'd0;
               state_d     = ST_INIT;
            end
         end
         ST_INIT: begin
            state_d = ST_ITER;
         end
         ST_ITER: begin
            // Counter parks on the last address so it is never stepped past the ROM.
            if (iter_cnt_q == ITER_LAST) begin
               state_d = ST_DONE;
            end else begin
               iter_cnt_d = iter_cnt_q + 4'd1;
            end
         end
         ST_DONE: begin
            if (iDone_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef CORDIC_CTRL_ABORT_EN
      if (iAbort && ((state_q == ST_INIT) || (state_q == ST_ITER))) begin
         state_d    = ST_IDLE;
         iter_cnt_d = 4'd0;
      end
`endif
   end

   always_comb begin
      oStart_ready     = 1'b0;
      oPhase_init_flag = 1'b0;
      oPhase_addr      = 4'd0;
      oRot_en          = 1'b0;
      oRot_dir         = 1'b0;
      oBusy            = 1'b1;
      oDone_valid      = 1'b0;
      oPhase_normalize = phase_cap_q;
      case (state_q)
         ST_IDLE: begin
            oStart_ready = 1'b1;
            oBusy        = 1'b0;
         end
         ST_INIT: begin
            oPhase_init_flag = 1'b1;
         end
         ST_ITER: begin
            // Sign passes straight through; the X/Y register stage closes the path.
            oRot_en     = 1'b1;
            oPhase_addr = iter_cnt_q;
            oRot_dir    = iPhase_sign;
         end
         ST_DONE: begin
            oDone_valid = 1'b1;
         end
         default: begin
            oBusy = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_fixedpoint_iteration_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_fixedpoint_iteration_ctrl
// Purpose  : Directed self-checking bench for cordic_fixedpoint_iteration_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_fixedpoint_iteration_ctrl;

   logic        iClk = 1'b0;
   logic        iReset_n;
   logic        iStart_valid;
   logic        oStart_ready;
   logic [21:0] iPhase_in;
   logic        oPhase_init_flag;
   logic [21:0] oPhase_normalize;
   logic [3:0]  oPhase_addr;
   logic        iPhase_sign;
   logic        oRot_en;
   logic        oRot_dir;
   logic        oBusy;
   logic        oDone_valid;
   logic        iDone_ready;
`ifdef CORDIC_CTRL_ABORT_EN
   logic        iAbort;
`endif

   int errors = 0;
   int checks = 0;

   always #5 iClk = ~iClk;

   cordic_fixedpoint_iteration_ctrl #(.N_ITER(16)) dut (
      .iClk             (iClk),
      .iReset_n         (iReset_n),
      .iStart_valid     (iStart_valid),
      .oStart_ready     (oStart_ready),
      .iPhase_in        (iPhase_in),
      .oPhase_init_flag (oPhase_init_flag),
      .oPhase_normalize (oPhase_normalize),
      .oPhase_addr      (oPhase_addr),
      .iPhase_sign      (iPhase_sign),
      .oRot_en          (oRot_en),
      .oRot_dir         (oRot_dir),
      .oBusy            (oBusy),
      .oDone_valid      (oDone_valid),
      .iDone_ready      (iDone_ready)
`ifdef CORDIC_CTRL_ABORT_EN
      ,
      .iAbort           (iAbort)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   // Runs the 16 ITER cycles; residual sign is driven high only at the given addresses.
   task automatic run_iter(input int neg_a, input int neg_b);
      for (int k = 0; k < 16; k++) begin
         step();
         iPhase_sign = ((k == neg_a) || (k == neg_b));
         #1;
         check($sformatf("iter%0d_rot_en", k), oRot_en, 1'b1);
         check($sformatf("iter%0d_addr", k), oPhase_addr, k[3:0]);
         check($sformatf("iter%0d_rot_dir", k), oRot_dir, iPhase_sign);
         check($sformatf("iter%0d_done", k), oDone_valid, 1'b0);
         check($sformatf("iter%0d_init", k), oPhase_init_flag, 1'b0);
      end
      iPhase_sign = 1'b0;
   endtask

   task automatic start_tx(input logic [21:0] phase);
      iStart_valid = 1'b1;
      iPhase_in    = phase;
      step();
      iStart_valid = 1'b0;
      check("init_flag", oPhase_init_flag, 1'b1);
      check("init_normalize", oPhase_normalize, phase);
      check("init_rot_en", oRot_en, 1'b0);
      check("init_busy", oBusy, 1'b1);
      check("init_start_ready", oStart_ready, 1'b0);
   endtask

   initial begin
      iReset_n     = 1'b0;
      iStart_valid = 1'b0;
      iPhase_in    = 22'h0;
      iPhase_sign  = 1'b1;
      iDone_ready  = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
      iAbort       = 1'b0;
`endif

      // Reset held three cycles, with start and sign asserted to prove they are masked
      iStart_valid = 1'b1;
      iPhase_in    = 22'h123456;
      repeat (3) step();
      check("rst_start_ready", oStart_ready, 1'b1);
      check("rst_init_flag", oPhase_init_flag, 1'b0);
      check("rst_rot_en", oRot_en, 1'b0);
      check("rst_rot_dir", oRot_dir, 1'b0);
      check("rst_busy", oBusy, 1'b0);
      check("rst_done", oDone_valid, 1'b0);
      check("rst_addr", oPhase_addr, 4'd0);
      check("rst_normalize", oPhase_normalize, 22'd0);
      iStart_valid = 1'b0;
      iPhase_sign  = 1'b0;
      iReset_n     = 1'b1;
      step();
      check("idle_start_ready", oStart_ready, 1'b1);

      // Single transaction with direction forwarding at addresses 3 and 7
      iDone_ready = 1'b1;
      start_tx(22'h0C90FD);
      run_iter(3, 7);
      step();
      check("tx1_done", oDone_valid, 1'b1);
      check("tx1_done_rot_en", oRot_en, 1'b0);
      check("tx1_done_addr", oPhase_addr, 4'd0);
      check("tx1_done_busy", oBusy, 1'b1);
      step();
      check("tx1_done_pulse", oDone_valid, 1'b0);
      check("tx1_idle_ready", oStart_ready, 1'b1);
      check("tx1_idle_busy", oBusy, 1'b0);

      // Backpressure in DONE with an ignored start
      iDone_ready = 1'b0;
      start_tx(22'h155555);
      run_iter(-1, -1);
      step();
      check("bp_done_rise", oDone_valid, 1'b1);
      iStart_valid = 1'b1;
      iPhase_in    = 22'h3FFFFF;
      for (int w = 0; w < 5; w++) begin
         step();
         check($sformatf("bp_wait%0d_done", w), oDone_valid, 1'b1);
         check($sformatf("bp_wait%0d_ready", w), oStart_ready, 1'b0);
         check($sformatf("bp_wait%0d_cap", w), oPhase_normalize, 22'h155555);
      end
      iDone_ready = 1'b1;
      iPhase_in   = 22'h2AAAAA;
      step();
      check("bp_idle_ready", oStart_ready, 1'b1);
      check("bp_idle_done", oDone_valid, 1'b0);
      check("bp_idle_cap", oPhase_normalize, 22'h155555);
      step();
      iStart_valid = 1'b0;
      check("bp_new_init", oPhase_init_flag, 1'b1);
      check("bp_new_cap", oPhase_normalize, 22'h2AAAAA);

      // Mid-operation reset at address 9
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("mr_addr%0d", k), oPhase_addr, k[3:0]);
      end
      iReset_n = 1'b0;
      step();
      iReset_n = 1'b1;
      check("mr_busy", oBusy, 1'b0);
      check("mr_ready", oStart_ready, 1'b1);
      check("mr_rot_en", oRot_en, 1'b0);
      check("mr_addr", oPhase_addr, 4'd0);
      check("mr_done", oDone_valid, 1'b0);
      check("mr_cap", oPhase_normalize, 22'd0);
      step();
      check("mr_no_done", oDone_valid, 1'b0);
      start_tx(22'h000001);
      run_iter(15, -1);
      step();
      check("mr_tx_done", oDone_valid, 1'b1);
      step();
      check("mr_tx_idle", oStart_ready, 1'b1);

`ifdef CORDIC_CTRL_ABORT_EN
      start_tx(22'h0ABCDE);
      for (int k = 0; k < 6; k++) step();
      check("ab_addr5", oPhase_addr, 4'd5);
      iAbort = 1'b1;
      step();
      iAbort = 1'b0;
      check("ab_busy", oBusy, 1'b0);
      check("ab_done", oDone_valid, 1'b0);
      iAbort       = 1'b1;
      iStart_valid = 1'b1;
      iPhase_in    = 22'h00ABCD;
      step();
      iAbort       = 1'b0;
      iStart_valid = 1'b0;
      check("ab_start_init", oPhase_init_flag, 1'b1);
      check("ab_start_cap", oPhase_normalize, 22'h00ABCD);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
